sram_frame_reader: RTL and testbench
====================================

# sram_frame_reader

Read-side SRAM client for the render path: converts VGA pixel requests into framebuffer addresses relative to a per-frame camera centred on the player, and fetches 16-bit RGB565 words. It expands each word to 24-bit colour with a fixed 2-cycle latency that matches the VGA timing generator. It sits between the VGA block and the shared SRAM port, opposite the frame encoder that writes the framebuffer. It tolerates cycles where the encoder owns the bus.

## Interface
- MAP_X_BITS, 10, map width = 2^MAP_X_BITS pixels
- MAP_Y_BITS, 10, map height = 2^MAP_Y_BITS pixels
- ADDR_W, 20, SRAM address width; must equal MAP_X_BITS+MAP_Y_BITS
- SCREEN_W, 640, visible width
- SCREEN_H, 480, visible height
- BG_COLOR, 24'h000000, colour for off-screen, idle and transparent pixels
- Clock and reset: one clock; reset is asynchronous and active-high.
- i_clk  in  1  system clock
- i_rst  in  1  asynchronous, active-high reset
- i_enable  in  1  reader runs when high
- i_frame_start  in  1  single-cycle pulse; latches the camera
- i_player_x  in  MAP_X_BITS  player map x, unsigned
- i_player_y  in  MAP_Y_BITS  player map y, unsigned
- i_req_valid  in  1  pixel request strobe
- i_VGA_H  in  10  requested screen column
- i_VGA_V  in  10  requested screen row
- i_sram_writing  in  1  encoder owns the SRAM this cycle
- o_sram_addr  out  ADDR_W  read address, registered
- i_sram_data  in  16  SRAM read data, RGB565
- o_color  out  24  expanded colour
- o_color_valid  out  1  o_color corresponds to a request issued 2 cycles earlier
- o_miss  out  1  pulse: fetch lost to a write cycle
- o_miss_count  out  16  misses this frame, saturating

## Operation
- FSM has two states. IDLE: no fetches are issued, o_color=BG_COLOR and o_color_valid=0. RUN: requests are serviced.
- IDLE→RUN on i_enable=1. RUN→IDLE on i_enable=0; requests already in flight still complete and emit their results.
- Camera latch on i_frame_start:
  - cam_x ← i_player_x − SCREEN_W/2, mod 2^MAP_X_BITS
  - cam_y ← i_player_y − SCREEN_H/2, mod 2^MAP_Y_BITS
  - The camera latches in either state. Its reset value is 0.
- Map coordinate: mx = (cam_x + i_VGA_H) mod 2^MAP_X_BITS; my likewise. Both axes wrap.
- Address: o_sram_addr = {my, mx}.
- Off-screen request (H ≥ SCREEN_W or V ≥ SCREEN_H): o_sram_addr holds its value, the result is BG_COLOR, and o_color_valid is still asserted.
- Colour expansion:
  - R = {r5, r5[4:2]}
  - G = {g6, g6[5:4]}
  - B = {b5, b5[4:2]}
- Bus conflict: if i_sram_writing=1 in the data-sample cycle, then:
  - i_sram_data is ignored;
  - o_color repeats the previous o_color;
  - o_miss pulses for 1 cycle;
  - o_miss_count increments and saturates at 16'hFFFF.
- o_miss_count clears on i_frame_start. If a clear and a miss occur in the same cycle, the count becomes 1.

## Timing
- Cycle N: request sampled (i_req_valid=1, state RUN).
- Cycle N+1: o_sram_addr valid. i_sram_data and i_sram_writing are sampled at the end of N+1.
- Cycle N+2: o_color and o_color_valid valid.
- The pipeline is fully pipelined: one request per cycle is accepted with no stalls.
- If i_frame_start and i_req_valid occur in the same cycle, that request uses the old camera; the new camera applies from N+1.
- Reset values: state IDLE, o_sram_addr 0, o_color BG_COLOR, o_color_valid 0, o_miss 0, o_miss_count 0, camera 0.
- Reset asserted mid-pipeline discards all in-flight requests. No output is produced for them after reset is released.

## Configuration
- SRAM_READER_TRANSPARENT_EN
  - Defined: a fetched word equal to 16'hF81F (magenta key) outputs BG_COLOR.
  - Undefined: 16'hF81F expands normally to 24'hFF00FF.
  - In both cases o_color_valid timing is unchanged.

## Test plan
- Camera and address: reset, enable, frame_start with player (512,300); request H=10, V=5 → o_sram_addr=20'h104CA at N+1. Return data 16'h8410 → o_color=24'h848284 with o_color_valid at N+2.
- Wrap-around: player_x=100 (cam_x=804); request H=300 → address low bits mx=80. Data 16'hFFFF → o_color=24'hFFFFFF.
- Off-screen: request H=700, V=10 → o_color=BG_COLOR with o_color_valid=1 at N+2, and o_sram_addr unchanged.
- Bus conflict: back-to-back requests with i_sram_writing=1 in the second request's sample cycle → the second output repeats the first colour, o_miss pulses once, o_miss_count=1. A following frame_start clears the count to 0.
- Transparency: data 16'hF81F → BG_COLOR with the macro defined, 24'hFF00FF without it.
- Reset and enable: assert i_rst while 2 requests are in flight → all outputs return to reset values and no o_color_valid appears after release. Drop i_enable → in-flight results still emerge, then o_color_valid=0.

Source files
------------

// File: rtl/sram_frame_reader.sv
// rtl/sram_frame_reader.sv - camera-relative SRAM pixel fetch with 2-cycle RGB565 to RGB888 expansion
// Optional: define SRAM_READER_TRANSPARENT_EN to map the 16'hF81F key word to BG_COLOR.
module sram_frame_reader #(
  parameter int          MAP_X_BITS = 10,
  parameter int          MAP_Y_BITS = 10,
  parameter int          ADDR_W     = 20,
  parameter int          SCREEN_W   = 640,
  parameter int          SCREEN_H   = 480,
  parameter logic [23:0] BG_COLOR   = 24'h000000
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_enable,
  input  logic                  i_frame_start,
  input  logic [MAP_X_BITS-1:0] i_player_x,
  input  logic [MAP_Y_BITS-1:0] i_player_y,
  input  logic                  i_req_valid,
  input  logic [9:0]            i_VGA_H,
  input  logic [9:0]            i_VGA_V,
  input  logic                  i_sram_writing,
  output logic [ADDR_W-1:0]     o_sram_addr,
  input  logic [15:0]           i_sram_data,
  output logic [23:0]           o_color,
  output logic                  o_color_valid,
  output logic                  o_miss,
  output logic [15:0]           o_miss_count
);

  localparam logic [10:0]           LP_SCREEN_W = 11'(SCREEN_W);
  localparam logic [10:0]           LP_SCREEN_H = 11'(SCREEN_H);
  localparam logic [MAP_X_BITS-1:0] LP_HALF_W   = MAP_X_BITS'(SCREEN_W / 2);
  localparam logic [MAP_Y_BITS-1:0] LP_HALF_H   = MAP_Y_BITS'(SCREEN_H / 2);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t                  r_state;
  state_t                  w_state_next;
  logic [MAP_X_BITS-1:0]   r_cam_x;
  logic [MAP_Y_BITS-1:0]   r_cam_y;
  logic                    r_s1_valid;
  logic                    r_s1_off;
  logic                    w_accept;
  logic                    w_offscreen;
  logic                    w_fetch_miss;
  logic [MAP_X_BITS-1:0]   w_mx;
  logic [MAP_Y_BITS-1:0]   w_my;
  logic [23:0]             w_expanded;
  logic [23:0]             w_color;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (i_enable)  w_state_next = S_RUN;
      S_RUN:   if (!i_enable) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  assign w_accept    = i_req_valid && (r_state == S_RUN);
  assign w_offscreen = ({1'b0, i_VGA_H} >= LP_SCREEN_W) || ({1'b0, i_VGA_V} >= LP_SCREEN_H);
  assign w_mx        = r_cam_x + MAP_X_BITS'(i_VGA_H);
  assign w_my        = r_cam_y + MAP_Y_BITS'(i_VGA_V);

  // Requests sampled alongside a frame_start still use the old camera.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cam_x     <= '0;
      r_cam_y     <= '0;
      r_s1_valid  <= 1'b0;
      r_s1_off    <= 1'b0;
      o_sram_addr <= '0;
    end else begin
      r_s1_valid <= w_accept;
      r_s1_off   <= w_offscreen;
      if (w_accept && !w_offscreen) o_sram_addr <= {w_my, w_mx};
      if (i_frame_start) begin
        r_cam_x <= i_player_x - LP_HALF_W;
        r_cam_y <= i_player_y - LP_HALF_H;
      end
    end
  end

  assign w_expanded = {i_sram_data[15:11], i_sram_data[15:13],
                       i_sram_data[10:5],  i_sram_data[10:9],
                       i_sram_data[4:0],   i_sram_data[4:2]};

`ifdef SRAM_READER_TRANSPARENT_EN
  assign w_color = (i_sram_data == 16'hF81F) ? BG_COLOR : w_expanded;
`else
  assign w_color = w_expanded;
`endif

  // Off-screen slots never touch the bus, so only real fetches can miss.
  assign w_fetch_miss = r_s1_valid && !r_s1_off && i_sram_writing;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_color       <= BG_COLOR;
      o_color_valid <= 1'b0;
      o_miss        <= 1'b0;
      o_miss_count  <= '0;
    end else begin
      o_color_valid <= r_s1_valid;
      o_miss        <= w_fetch_miss;
      if (r_s1_valid) begin
        if (r_s1_off)             o_color <= BG_COLOR;
        else if (!i_sram_writing) o_color <= w_color;
      end else if (r_state == S_IDLE) begin
        o_color <= BG_COLOR;
      end
      if (i_frame_start)
        o_miss_count <= w_fetch_miss ? 16'd1 : 16'd0;
      else if (w_fetch_miss && (o_miss_count != 16'hFFFF))
        o_miss_count <= o_miss_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_sram_frame_reader.sv
// tb/tb_sram_frame_reader.sv - scoreboard bench for sram_frame_reader
module tb_sram_frame_reader;

  localparam logic [23:0] BG = 24'h000000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        fs = 1'b0;
  logic [9:0]  px = '0;
  logic [9:0]  py = '0;
  logic        req = 1'b0;
  logic [9:0]  vh = '0;
  logic [9:0]  vv = '0;
  logic        wr = 1'b0;
  logic [15:0] dat = '0;
  logic [19:0] addr;
  logic [23:0] color;
  logic        cvalid;
  logic        miss;
  logic [15:0] miss_cnt;

  logic [24:0] exp_q[$];
  int          n_checks = 0;
  int          n_fail = 0;
  logic [23:0] trans_exp;

  sram_frame_reader dut (
    .i_clk(clk), .i_rst(rst), .i_enable(en), .i_frame_start(fs),
    .i_player_x(px), .i_player_y(py), .i_req_valid(req),
    .i_VGA_H(vh), .i_VGA_V(vv), .i_sram_writing(wr),
    .o_sram_addr(addr), .i_sram_data(dat), .o_color(color),
    .o_color_valid(cvalid), .o_miss(miss), .o_miss_count(miss_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock: drive request and the data/writing for the previous request, then return 1 after the edge.
  task automatic cyc(input logic r, input logic [9:0] h, input logic [9:0] v,
                     input logic [15:0] d, input logic w, input logic f);
    req = r; vh = h; vv = v; dat = d; wr = w; fs = f;
    @(posedge clk); #1;
    req = 1'b0; wr = 1'b0; fs = 1'b0;
  endtask

  task automatic expect_out(input logic [23:0] c, input logic m);
    exp_q.push_back({m, c});
  endtask

  initial begin
    logic [24:0] e;
`ifdef SRAM_READER_TRANSPARENT_EN
    trans_exp = BG;
`else
    trans_exp = 24'hFF00FF;
`endif
    fork
      forever begin
        @(negedge clk);
        if (!rst) begin
          if (cvalid) begin
            if (exp_q.size() == 0) begin
              chk("unexpected_valid", 32'(cvalid), 32'd0);
            end else begin
              e = exp_q.pop_front();
              chk("color", 32'(color), 32'(e[23:0]));
              chk("miss", 32'(miss), 32'(e[24]));
            end
          end else if (miss) begin
            chk("miss_without_valid", 32'(miss), 32'd0);
          end
        end
      end
    join_none

    repeat (2) @(posedge clk);
    #1;
    chk("rst_color", 32'(color), 32'(BG));
    chk("rst_valid", 32'(cvalid), 32'd0);
    chk("rst_addr", 32'(addr), 32'd0);
    chk("rst_miss", 32'(miss), 32'd0);
    chk("rst_miss_cnt", 32'(miss_cnt), 32'd0);
    rst = 1'b0;

    // Camera (192,60); H=10 V=5 -> {65,202}
    en = 1'b1; px = 10'd512; py = 10'd300;
    cyc(0, 0, 0, 16'h0, 0, 1);
    cyc(1, 10'd10, 10'd5, 16'h0, 0, 0);
    chk("addr_basic", 32'(addr), 32'h104CA);
    expect_out(24'h848284, 1'b0);
    cyc(0, 0, 0, 16'h8410, 0, 0);
    cyc(0, 0, 0, 16'h0, 0, 0);

    // Wrap: cam_x = 804, H=300 -> mx 80
    px = 10'd100;
    cyc(0, 0, 0, 16'h0, 0, 1);
    cyc(1, 10'd300, 10'd5, 16'h0, 0, 0);
    chk("addr_wrap", 32'(addr), 32'h10450);
    expect_out(24'hFFFFFF, 1'b0);
    cyc(0, 0, 0, 16'hFFFF, 0, 0);

    // Off-screen: address holds
    cyc(1, 10'd700, 10'd10, 16'h0, 0, 0);
    chk("addr_offscreen_hold", 32'(addr), 32'h10450);
    expect_out(BG, 1'b0);
    cyc(0, 0, 0, 16'h1234, 0, 0);
    cyc(1, 10'd5, 10'd480, 16'h0, 0, 0);
    chk("addr_offscreen_v_hold", 32'(addr), 32'h10450);
    expect_out(BG, 1'b0);
    cyc(0, 0, 0, 16'h1234, 0, 0);

    // Bus conflict: second fetch lost, colour repeats
    cyc(1, 10'd0, 10'd0, 16'h0, 0, 0);
    chk("addr_conflict_a", 32'(addr), 32'h0F324);
    expect_out(24'h0000FF, 1'b0);
    cyc(1, 10'd1, 10'd0, 16'h001F, 0, 0);
    chk("addr_conflict_b", 32'(addr), 32'h0F325);
    expect_out(24'h0000FF, 1'b1);
    cyc(0, 0, 0, 16'hFFFF, 1, 0);
    chk("miss_cnt_one", 32'(miss_cnt), 32'd1);
    cyc(0, 0, 0, 16'h0, 0, 1);
    chk("miss_cnt_clear", 32'(miss_cnt), 32'd0);

    // Clear and miss in the same cycle -> 1
    cyc(1, 10'd2, 10'd0, 16'h0, 0, 0);
    expect_out(24'h0000FF, 1'b1);
    cyc(0, 0, 0, 16'hFFFF, 1, 1);
    chk("miss_cnt_clear_and_miss", 32'(miss_cnt), 32'd1);

    // Transparency key
    cyc(1, 10'd3, 10'd0, 16'h0, 0, 0);
    expect_out(trans_exp, 1'b0);
    cyc(0, 0, 0, 16'hF81F, 0, 0);
    cyc(0, 0, 0, 16'h0, 0, 0);

    // Reset with two requests in flight
    cyc(1, 10'd10, 10'd5, 16'h0, 0, 0);
    cyc(1, 10'd20, 10'd5, 16'h8410, 0, 0);
    rst = 1'b1;
    #1;
    chk("midrst_valid", 32'(cvalid), 32'd0);
    chk("midrst_color", 32'(color), 32'(BG));
    chk("midrst_addr", 32'(addr), 32'd0);
    chk("midrst_miss_cnt", 32'(miss_cnt), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("post_rst_no_valid", 32'(cvalid), 32'd0);
    end

    // Drop enable with one request in flight
    @(posedge clk); #1;
    px = 10'd512; py = 10'd300;
    cyc(0, 0, 0, 16'h0, 0, 1);
    cyc(1, 10'd10, 10'd5, 16'h0, 0, 0);
    chk("addr_after_rst", 32'(addr), 32'h104CA);
    expect_out(24'h848284, 1'b0);
    en = 1'b0;
    cyc(1, 10'd11, 10'd5, 16'h8410, 0, 0);
    expect_out(24'h848284, 1'b0);
    cyc(0, 0, 0, 16'h8410, 0, 0);
    cyc(1, 10'd12, 10'd5, 16'h0, 0, 0);
    cyc(0, 0, 0, 16'h0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("idle_no_valid", 32'(cvalid), 32'd0);
    end
    chk("idle_color_bg", 32'(color), 32'(BG));

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
